// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one unsigned multi_4bits multiplier between two
// valid/ready requesters; product is registered and returned on the winner's channel.

module multi_4bits #(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0]   a,
  input  logic [BITS-1:0]   b,
  output logic [2*BITS-1:0] product
);
  assign product = {{BITS{1'b0}}, a} * {{BITS{1'b0}}, b};
endmodule

module mult_sched #(
  parameter int BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [BITS-1:0]   req0_a,
  input  logic [BITS-1:0]   req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [BITS-1:0]   req1_a,
  input  logic [BITS-1:0]   req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [2*BITS-1:0] rsp_product,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [BITS-1:0]     op_a_reg, op_b_reg;
  logic [2*BITS-1:0]   prod_reg;
  logic                owner_reg;
  logic                prio_reg;
  logic [2*BITS-1:0]   mul_product;

  logic [1:0] req_valid, req_ready, rsp_ready, rsp_valid, grant;
  logic       transfer;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      // A lone requester always wins; a contested grant goes to the priority channel.
      assign grant[gi]     = req_valid[gi] & (~req_valid[1-gi] | (prio_reg == 1'(gi)));
      // Gated by rst so ready reads as 0 for the whole time reset is held.
      assign req_ready[gi] = (state_reg == IDLE) & ~rst & grant[gi];
      assign rsp_valid[gi] = (state_reg == RESP) & (owner_reg == 1'(gi));
    end
  endgenerate

  assign transfer    = |req_ready;
  assign req0_ready  = req_ready[0];
  assign req1_ready  = req_ready[1];
  assign rsp0_valid  = rsp_valid[0];
  assign rsp1_valid  = rsp_valid[1];
  assign rsp_product = prod_reg;
  assign busy        = (state_reg != IDLE);

  multi_4bits #(.BITS(BITS)) u_mul (
    .a       (op_a_reg),
    .b       (op_b_reg),
    .product (mul_product)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (transfer) state_next = CALC;
      CALC:    state_next = RESP;
      RESP:    if (rsp_ready[owner_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      prod_reg  <= '0;
      owner_reg <= 1'b0;
      prio_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && transfer) begin
        op_a_reg  <= grant[1] ? req1_a : req0_a;
        op_b_reg  <= grant[1] ? req1_b : req0_b;
        owner_reg <= grant[1];
      end
      if (state_reg == CALC)
        prod_reg <= mul_product;
      // Priority flips only once the owner has actually taken its product.
      if (state_reg == RESP && rsp_ready[owner_reg])
        prio_reg <= ~owner_reg;
    end
  end

endmodule
